// File: rtl/bus_slave_if.sv
// Bus connection between the system-bus master side and one memory-backed slave.
// The master drives the request fields and the slave drives the response fields.
interface bus_slave_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int U_ADDR_WIDTH = 12,
    parameter int RESP_W       = 2
) ();
    logic                    h_sel;
    logic                    h_write;
    logic [U_ADDR_WIDTH-1:0] h_addr;
    logic [DATA_WIDTH-1:0]   h_wdata;
    logic                    h_ready;
    logic [RESP_W-1:0]       h_resp;
    logic [DATA_WIDTH-1:0]   h_rdata;
    logic                    h_rdata_valid;

    modport master (
        output h_sel, h_write, h_addr, h_wdata,
        input  h_ready, h_resp, h_rdata, h_rdata_valid
    );

    modport slave (
        input  h_sel, h_write, h_addr, h_wdata,
        output h_ready, h_resp, h_rdata, h_rdata_valid
    );
endinterface

// File: rtl/bus_slave.sv
// Memory-backed bus responder: captures one transfer, waits WAIT_STATES cycles,
// then issues a one-cycle response (OKAY / ERROR / RETRY) with read data.
// Stays in HOLD until h_sel drops so a held request is served only once.
module bus_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int U_ADDR_WIDTH = 12,
    parameter int RESP_COUNT   = 4,
    parameter int MEM_DEPTH    = 1024,
    parameter int WAIT_STATES  = 2
) (
    input  logic           clk,
    input  logic           rst,
    bus_slave_if.slave     bus,
    input  logic           sl_busy
);
    localparam int RESP_W = (RESP_COUNT > 1) ? $clog2(RESP_COUNT) : 1;
    localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [RESP_W-1:0]       RESP_OKAY  = RESP_W'(0);
    localparam logic [RESP_W-1:0]       RESP_ERROR = RESP_W'(1);
    localparam logic [RESP_W-1:0]       RESP_RETRY = RESP_W'(2);
    // One extra bit so MEM_DEPTH == 2**U_ADDR_WIDTH is representable.
    localparam logic [U_ADDR_WIDTH:0]   DEPTH_LIMIT = (U_ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]        CNT_LOAD    = CNT_W'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [U_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    ready_q, ready_d;
    logic [RESP_W-1:0]       resp_q, resp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    valid_q, valid_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic                    addr_err;
    logic                    mem_we;
    logic [MEM_AW-1:0]       mem_idx;

    // Decision terms evaluated only while in RESP (the response edge).
    assign addr_err = ({1'b0, addr_q} >= DEPTH_LIMIT);
    assign mem_idx  = addr_q[MEM_AW-1:0];
    assign mem_we   = (state_q == S_RESP) && !addr_err && !sl_busy && write_q;

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        resp_d  = RESP_OKAY;
        rdata_d = '0;
        valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.h_sel) begin
                    write_d = bus.h_write;
                    addr_d  = bus.h_addr;
                    wdata_d = bus.h_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!bus.h_sel) begin
                    // Master withdrew the request: abandon it silently.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                ready_d = 1'b1;
                state_d = S_HOLD;
                if (addr_err) begin
                    resp_d = RESP_ERROR;
                end else if (sl_busy) begin
                    resp_d = RESP_RETRY;
                end else if (!write_q) begin
                    rdata_d = mem[mem_idx];
                    valid_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (!bus.h_sel) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            resp_q  <= RESP_OKAY;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    // Storage array written on the OKAY-write response edge.
    // NOTE: the memory has no reset; contents survive rst by design.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign bus.h_ready       = ready_q;
    assign bus.h_resp        = resp_q;
    assign bus.h_rdata       = rdata_q;
    assign bus.h_rdata_valid = valid_q;
endmodule
